// File: rtl/neander_prog_loader.sv
// Program loader for the Neander CPU: accepts a framed byte stream (length, payload, checksum),
// writes the payload into program RAM from address 0 and holds the CPU in reset until a good frame.
module neander_prog_loader #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned MAX_LEN = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        count
);

    localparam logic [8:0] MaxLen = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic accept;
    logic len_ok;
    logic last_byte;
    logic sum_ok;

    assign accept    = in_valid & in_ready;
    assign len_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= MaxLen);
    assign last_byte = (count_q + 8'd1) == len_q;
    assign sum_ok    = in_data == sum_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                if (accept) state_d = len_ok ? StData : StErr;
            end
            StData: begin
                if (accept && last_byte) state_d = StChk;
            end
            StChk: begin
                if (accept) state_d = sum_ok ? StDone : StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values; everything but in_ready is registered below
    always_comb begin
        in_ready   = 1'b0;
        len_d      = len_q;
        sum_d      = sum_q;
        count_d    = count_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        cpu_rst_d  = cpu_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                    count_d   = 8'd0;
                    sum_d     = 8'd0;
                end
            end
            StLen: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (len_ok) begin
                        len_d = in_data;
                    end else begin
                        busy_d = 1'b0;
                        err_d  = 1'b1;
                    end
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (accept) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = count_q[ADDR_W-1:0];
                    mem_din_d  = in_data;
                    count_d    = count_q + 8'd1;
                    sum_d      = sum_q + in_data;
                end
            end
            StChk: begin
                in_ready = 1'b1;
                if (accept) begin
                    busy_d = 1'b0;
                    if (sum_ok) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= 8'd0;
            sum_q      <= 8'd0;
            count_q    <= 8'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 8'd0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule
